r_resp_reorder: RTL and testbench
=================================

# r_resp_reorder

Response-side reorder buffer for single-beat AXI reads that pairs with the ID allocator/tag map. It accepts R beats tagged with an internal unique ID (`{row, col}`) in any order and buffers them per slot. Within each row it releases them in column (issue) order, which preserves AXI same-ID ordering. On each release it frees the unique ID in the tag map and restores the original RID.

## Interface
Parameters:
- `ID_WIDTH`, 4, original AXI ID width (RID out)
- `DATA_WIDTH`, 32, RDATA width
- `NUM_ROWS`, 4, tag map rows; must match the allocator
- `NUM_COLS`, 4, tag map columns per row; must match the allocator
- Derived: `ROW_W = NUM_ROWS>1 ? clog2(NUM_ROWS) : 1`; `COL_W` likewise from `NUM_COLS`; `UID_W = ROW_W + COL_W`

Ports:
- `clk`  in  1  clock; one clock domain
- `rst`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  downstream R beat valid
- `in_ready`  out  1  beat accepted when `in_valid && in_ready`
- `in_uid`  in  UID_W  unique ID of the beat; `[UID_W-1:COL_W]` = row, `[COL_W-1:0]` = col
- `in_data`  in  DATA_WIDTH  RDATA
- `in_resp`  in  2  RRESP
- `out_valid`  out  1  upstream R beat valid
- `out_ready`  in  1  upstream accepts the beat
- `out_id`  out  ID_WIDTH  restored original RID
- `out_data`  out  DATA_WIDTH  RDATA
- `out_resp`  out  2  RRESP
- `out_last`  out  1  constant 1 (single-beat reads only)
- `free_req`  out  1  one-cycle pulse that frees `free_unique_id` in the tag map
- `free_unique_id`  out  UID_W  slot being released
- `restored_id`  in  ID_WIDTH  tag map lookup of `free_unique_id`, valid combinationally while `free_req` is high

## Operation
**State**
- Per slot `[r][c]`: `slot_valid`, `data`, `resp`.
- Per row: `exp_col[r]` (COL_W bits), the next column to release.
- Round-robin pointer `rr_q` (ROW_W bits).
- Output register: `out_valid`, `out_id`, `out_data`, `out_resp`.

**Accept**
- `in_ready = !rst && !slot_valid_q[in_row][in_col]`.
- Accepting writes `data`/`resp` and sets `slot_valid` at the next edge.
- A UID whose slot is occupied stalls the input; it is never overwritten.
- `in_row >= NUM_ROWS` is undefined and excluded by construction.

**Release candidates**
- Row `r` is a candidate when `slot_valid_q[r][exp_col_q[r]]` is set.

**Load condition**
- `load = any_candidate && (!out_valid || out_ready)`.

**Arbitration**
- Select the first candidate row at or after `rr_q + 1` (mod NUM_ROWS).
- On `load`: `rr_q <= sel`.

**On `load` (all in the same cycle)**
- `free_req = 1`, `free_unique_id = {sel, exp_col_q[sel]}`.
- Capture `out_id <= restored_id`, `out_data`/`out_resp <= slot contents`, `out_valid <= 1`.
- Clear that `slot_valid`.
- `exp_col[sel] <= exp_col + 1`, wrapping from NUM_COLS-1 to 0.

**Output register**
- With no `load` and `out_valid && out_ready`, `out_valid <= 0`.
- Holds its beat stable while `out_valid && !out_ready`.

**`exp_col` sequencing**
- `exp_col` never resets except on `rst`.
- It tracks the allocator's monotonic per-row column pointer, so no alloc snoop is required.

**Simultaneous events**
- Accept and release of the same slot in one cycle cannot occur: `in_ready` uses the registered `slot_valid`, so a slot being released is still seen as occupied that cycle.
- Accept and release of different slots in one cycle are both performed.

**Interface rules**
- `free_ack` from the tag map is not used.
- The tag map's `restored_id` must be combinational.

## Timing
**Reset values**
- All `slot_valid`, `exp_col`, `rr_q` = 0.
- `out_valid = 0`, `out_id/out_data/out_resp = 0`, `free_req = 0`.
- `in_ready = 0` while `rst` is high; it is 1 in the first cycle after reset.

**Latency**
- Beat accepted at edge N with its slot expected and the output free: `free_req` high in cycle N+1, `out_valid` high from edge N+1.
- Minimum 1 cycle register-to-output; there is no input-to-output bypass.

**Throughput**
- 1 beat/cycle sustained when beats arrive in order and `out_ready = 1`.

**Out-of-order arrival**
- A beat arriving ahead of `exp_col` waits until all earlier columns of its row have been released.

**Reset mid-operation**
- Buffered beats are dropped, the output beat is dropped, and no `free_req` is issued.
- The allocator must be reset in the same cycle.

## Test plan
1. **In-order single beat:** after reset, `in_uid=0x0`, `data=0xA5A5A5A5`, `resp=0`; tag map returns `restored_id=3`.
   - Required: `free_req` with `free_unique_id=0x0` one cycle after accept.
   - Required: `out_valid`, `out_id=3`, `out_data=0xA5A5A5A5`, `out_last=1`.
2. **Out of order within a row:** send `in_uid` 0x2, then 0x1, then 0x0 (row 0).
   - Required: no `out_valid` until uid 0x0 is accepted.
   - Required: output order uid 0, 1, 2 on consecutive cycles with `out_ready=1`; three `free_req` pulses.
3. **Two rows contending:** beats for uid 0x0 (row 0) and 0x4 (row 1) are buffered while `out_ready=0`; then raise `out_ready`.
   - Required: releases alternate by round-robin.
   - Required: row 1 is not starved when row 0 has a continuous stream.
4. **Backpressure and full:** hold `out_ready=0`, fill all 16 slots.
   - Required: `in_ready=0` for any occupied UID.
   - Required: the held beat stays stable.
   - Required: draining returns all 16 beats in per-row column order.
5. **Wrap:** send 6 in-order beats to row 2 (cols 0,1,2,3,0,1).
   - Required: `exp_col[2]` wraps 3→0.
   - Required: all 6 beats are released with correct `free_unique_id` values 0x8–0xB, then 0x8, 0x9.
6. **Reset mid-operation:** with 3 beats buffered and `out_valid=1`, assert `rst` for 1 cycle.
   - Required: `out_valid=0` and `free_req=0` in the cycle after.
   - Required: `in_ready=1` for uid 0x0 after reset.
   - Required: a new uid 0x0 beat is released normally.

Source files
------------

// File: rtl/r_resp_reorder_if.sv
// R-beat bundle between the downstream (tagged) side, the upstream (restored RID) side
// and the tag-map free/lookup port of the response reorder buffer.
interface r_resp_reorder_if #(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_ROWS   = 4,
  parameter int NUM_COLS   = 4
);
  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int UID_W = ROW_W + COL_W;

  logic                  in_valid;
  logic                  in_ready;
  logic [UID_W-1:0]      in_uid;
  logic [DATA_WIDTH-1:0] in_data;
  logic [1:0]            in_resp;

  logic                  out_valid;
  logic                  out_ready;
  logic [ID_WIDTH-1:0]   out_id;
  logic [DATA_WIDTH-1:0] out_data;
  logic [1:0]            out_resp;
  logic                  out_last;

  logic                  free_req;
  logic [UID_W-1:0]      free_unique_id;
  logic [ID_WIDTH-1:0]   restored_id;

  modport slave (
    input  in_valid, in_uid, in_data, in_resp, out_ready, restored_id,
    output in_ready, out_valid, out_id, out_data, out_resp, out_last,
           free_req, free_unique_id
  );

  modport master (
    output in_valid, in_uid, in_data, in_resp, out_ready, restored_id,
    input  in_ready, out_valid, out_id, out_data, out_resp, out_last,
           free_req, free_unique_id
  );
endinterface

// File: rtl/r_resp_reorder.sv
// Reorder buffer for single-beat AXI R responses: buffers beats per {row,col} slot,
// releases each row in column order, frees the UID and restores the original RID.
module r_resp_reorder #(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_ROWS   = 4,
  parameter int NUM_COLS   = 4
) (
  input logic             clk,
  input logic             rst,
  r_resp_reorder_if.slave bus
);
  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int UID_W = ROW_W + COL_W;

  typedef logic [ROW_W-1:0] row_t;
  typedef logic [COL_W-1:0] col_t;

  logic [NUM_COLS-1:0]   slot_valid_q [NUM_ROWS];
  logic [DATA_WIDTH-1:0] data_q       [NUM_ROWS][NUM_COLS];
  logic [1:0]            resp_q       [NUM_ROWS][NUM_COLS];
  col_t                  exp_col_q    [NUM_ROWS];
  row_t                  rr_q;

  logic                  out_valid_q;
  logic [ID_WIDTH-1:0]   out_id_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [1:0]            out_resp_q;

  row_t                  in_row;
  col_t                  in_col;
  logic                  accept;
  logic [NUM_ROWS-1:0]   cand;
  logic                  any_cand;
  row_t                  sel;
  col_t                  sel_col;
  col_t                  exp_next;
  logic                  load;

  assign in_row = bus.in_uid[UID_W-1:COL_W];
  assign in_col = bus.in_uid[COL_W-1:0];

  // Registered occupancy only: a slot being released this cycle still reads as busy.
  assign bus.in_ready = !rst && !slot_valid_q[in_row][in_col];
  assign accept       = bus.in_valid && bus.in_ready;

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_cand
    assign cand[r] = slot_valid_q[r][exp_col_q[r]];
  end

  // Round-robin: first candidate row at or after rr_q + 1, wrapping.
  always_comb begin
    int unsigned idx;
    sel      = rr_q;
    any_cand = 1'b0;
    idx      = 0;
    for (int unsigned k = 1; k <= NUM_ROWS; k++) begin
      idx = (32'(rr_q) + k) % 32'(NUM_ROWS);
      if (!any_cand && cand[row_t'(idx)]) begin
        any_cand = 1'b1;
        sel      = row_t'(idx);
      end
    end
  end

  assign sel_col  = exp_col_q[sel];
  assign exp_next = (sel_col == col_t'(NUM_COLS - 1)) ? '0 : sel_col + col_t'(1);
  assign load     = !rst && any_cand && (!out_valid_q || bus.out_ready);

  assign bus.free_req       = load;
  assign bus.free_unique_id = {sel, sel_col};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < NUM_ROWS; r++) begin
        slot_valid_q[r] <= '0;
        exp_col_q[r]    <= '0;
      end
      rr_q        <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_data_q  <= '0;
      out_resp_q  <= '0;
    end else begin
      if (load) begin
        slot_valid_q[sel][sel_col] <= 1'b0;
        exp_col_q[sel]             <= exp_next;
        rr_q                       <= sel;
        out_valid_q                <= 1'b1;
        out_id_q                   <= bus.restored_id;
        out_data_q                 <= data_q[sel][sel_col];
        out_resp_q                 <= resp_q[sel][sel_col];
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (accept) begin
        slot_valid_q[in_row][in_col] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      data_q[in_row][in_col] <= bus.in_data;
      resp_q[in_row][in_col] <= bus.in_resp;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_id    = out_id_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_resp  = out_resp_q;
  assign bus.out_last  = 1'b1;
endmodule

// File: tb/tb_r_resp_reorder.sv
// Bench for r_resp_reorder: directed scenarios plus allocator-shaped random traffic,
// checked every cycle against a slot/queue reference model of the release rules.
module tb_r_resp_reorder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  r_resp_reorder_if #(.ID_WIDTH(4), .DATA_WIDTH(32), .NUM_ROWS(4), .NUM_COLS(4)) bus ();

  r_resp_reorder #(.ID_WIDTH(4), .DATA_WIDTH(32), .NUM_ROWS(4), .NUM_COLS(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic        v    = 1'b0;
  logic [3:0]  uid  = '0;
  logic [31:0] dat  = '0;
  logic [1:0]  rsp  = '0;
  logic        ordy = 1'b0;
  logic [3:0]  tag_id [16];

  assign bus.in_valid    = v;
  assign bus.in_uid      = uid;
  assign bus.in_data     = dat;
  assign bus.in_resp     = rsp;
  assign bus.out_ready   = ordy;
  assign bus.restored_id = tag_id[bus.free_unique_id];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: buffered beats per UID, next column per row, last served row.
  bit          mv [16];
  logic [31:0] md [16];
  logic [1:0]  mr [16];
  int          nxt [4];
  int          rel_cnt [4];
  int          last_row;
  bit          ov;
  logic [3:0]  oid;
  logic [31:0] od;
  logic [1:0]  ors;

  int log_uid [$];
  int log_cyc [$];
  int exp_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nxt[i]     = 0;
      rel_cnt[i] = 0;
    end
    last_row = 0;
    ov  = 1'b0;
    oid = '0;
    od  = '0;
    ors = '0;
  endtask

  // One clock cycle: inputs already applied after the falling edge.
  task automatic step();
    bit e_ready, e_load;
    int e_sel, eu, r;
    #1;
    e_ready = !rst && !mv[uid];
    e_load  = 1'b0;
    e_sel   = 0;
    if (!rst && (!ov || ordy)) begin
      for (int k = 1; k <= 4; k++) begin
        r = (last_row + k) % 4;
        if (!e_load && mv[r*4 + nxt[r]]) begin
          e_load = 1'b1;
          e_sel  = r;
        end
      end
    end
    eu = e_sel*4 + nxt[e_sel];
    chk("in_ready", 64'(bus.in_ready), 64'(e_ready));
    chk("free_req", 64'(bus.free_req), 64'(e_load));
    if (e_load) chk("free_unique_id", 64'(bus.free_unique_id), 64'(eu));
    chk("out_valid", 64'(bus.out_valid), 64'(ov));
    if (ov) begin
      chk("out_id", 64'(bus.out_id), 64'(oid));
      chk("out_data", 64'(bus.out_data), 64'(od));
      chk("out_resp", 64'(bus.out_resp), 64'(ors));
      chk("out_last", 64'(bus.out_last), 64'(1));
    end
    if (bus.free_req === 1'b1) begin
      log_uid.push_back(int'(bus.free_unique_id));
      log_cyc.push_back(cyc);
    end
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      if (e_load) begin
        ov  = 1'b1;
        oid = tag_id[eu];
        od  = md[eu];
        ors = mr[eu];
        mv[eu] = 1'b0;
        nxt[e_sel] = (nxt[e_sel] + 1) % 4;
        rel_cnt[e_sel]++;
        last_row = e_sel;
      end else if (ov && ordy) begin
        ov = 1'b0;
      end
      if (v && e_ready) begin
        mv[uid] = 1'b1;
        md[uid] = dat;
        mr[uid] = rsp;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drive(input bit iv, input int iu, input logic [31:0] id,
                       input logic [1:0] ir, input bit ordy_i);
    v    = iv;
    uid  = 4'(iu);
    dat  = id;
    rsp  = ir;
    ordy = ordy_i;
    step();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    v   = 1'b0;
    repeat (n) step();
    rst = 1'b0;
    log_uid.delete();
    log_cyc.delete();
  endtask

  task automatic chk_log(input string tag);
    chk({tag, "_len"}, 64'(log_uid.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_uid.size(); i++)
      chk(tag, 64'(log_uid[i]), 64'(exp_q[i]));
  endtask

  int order [16];
  int colcnt [4];
  int issued [4];
  int ap [4];
  int pool [$];
  int total, pick, pi, rr, tmp, acc_cyc, u;
  bit acc;

  initial begin
    for (int i = 0; i < 16; i++) tag_id[i] = 4'(i ^ 5);
    tag_id[0] = 4'd3;
    model_clear();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    do_reset(1);
    chk("rst_out_id", 64'(bus.out_id), 64'(0));
    chk("rst_out_data", 64'(bus.out_data), 64'(0));
    chk("rst_out_resp", 64'(bus.out_resp), 64'(0));

    // 1: in-order single beat
    acc_cyc = cyc;
    drive(1, 0, 32'hA5A5A5A5, 2'd0, 1);
    drive(0, 0, 0, 0, 1);
    #1;
    chk("t1_out_valid", 64'(bus.out_valid), 64'(1));
    chk("t1_out_id", 64'(bus.out_id), 64'(3));
    chk("t1_out_data", 64'(bus.out_data), 64'h0000_0000_A5A5_A5A5);
    drive(0, 0, 0, 0, 1);
    exp_q = '{0};
    chk_log("t1_free");
    if (log_cyc.size() > 0) chk("t1_free_cycle", 64'(log_cyc[0]), 64'(acc_cyc + 1));

    // 2: out of order within row 0
    do_reset(1);
    drive(1, 2, $urandom, 2'd1, 1);
    drive(1, 1, $urandom, 2'd2, 1);
    chk("t2_no_early", 64'(log_uid.size()), 64'(0));
    drive(1, 0, $urandom, 2'd3, 1);
    repeat (5) drive(0, 0, 0, 0, 1);
    exp_q = '{0, 1, 2};
    chk_log("t2_order");
    if (log_cyc.size() == 3) chk("t2_consecutive", 64'(log_cyc[2] - log_cyc[0]), 64'(2));

    // 3: two rows contending under backpressure
    do_reset(1);
    drive(1, 0, $urandom, 0, 0);
    drive(1, 4, $urandom, 0, 0);
    drive(1, 1, $urandom, 0, 0);
    drive(1, 5, $urandom, 0, 0);
    drive(1, 2, $urandom, 0, 0);
    drive(1, 3, $urandom, 0, 0);
    repeat (3) drive(0, 0, 0, 0, 0);
    repeat (10) drive(0, 0, 0, 0, 1);
    exp_q = '{0, 4, 1, 5, 2, 3};
    chk_log("t3_rr");

    // 4: fill all slots with the output stalled, then drain
    do_reset(1);
    for (int i = 0; i < 16; i++) order[i] = i;
    for (int i = 15; i > 0; i--) begin
      pick = $urandom_range(0, i);
      tmp = order[i];
      order[i] = order[pick];
      order[pick] = tmp;
    end
    for (int i = 0; i < 16; i++) drive(1, order[i], $urandom, 2'($urandom), 0);
    for (int i = 0; i < 6; i++) begin
      u = $urandom_range(0, 15);
      for (int j = 0; j < 16 && !mv[u]; j++) u = (u + 1) % 16;
      drive(1, u, $urandom, 0, 0);
    end
    repeat (5) drive(0, 0, 0, 0, 0);
    repeat (24) drive(0, 0, 0, 0, 1);
    chk("t4_count", 64'(log_uid.size()), 64'(16));
    for (int i = 0; i < 4; i++) colcnt[i] = 0;
    foreach (log_uid[i]) begin
      chk("t4_row_order", 64'(log_uid[i] % 4), 64'(colcnt[log_uid[i] / 4]));
      colcnt[log_uid[i] / 4]++;
    end

    // 5: column wrap in row 2
    do_reset(1);
    for (int i = 0; i < 6; i++) drive(1, 8 + (i % 4), $urandom, 2'($urandom), 1);
    repeat (4) drive(0, 0, 0, 0, 1);
    exp_q = '{8, 9, 10, 11, 8, 9};
    chk_log("t5_wrap");
    if (log_cyc.size() == 6) chk("t5_throughput", 64'(log_cyc[5] - log_cyc[0]), 64'(5));

    // 6: reset mid-operation
    do_reset(1);
    for (int i = 0; i < 4; i++) drive(1, i, $urandom, 0, 0);
    chk("t6_pre_valid", 64'(bus.out_valid), 64'(1));
    do_reset(1);
    #1;
    chk("t6_out_valid", 64'(bus.out_valid), 64'(0));
    chk("t6_free_req", 64'(bus.free_req), 64'(0));
    v = 1'b1;
    uid = 4'd0;
    #1;
    chk("t6_in_ready", 64'(bus.in_ready), 64'(1));
    drive(1, 0, 32'h1234_5678, 2'd2, 1);
    repeat (3) drive(0, 0, 0, 0, 1);
    exp_q = '{0};
    chk_log("t6_after");

    // Random allocator-shaped traffic with random backpressure
    for (int i = 0; i < 16; i++) tag_id[i] = 4'($urandom);
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      issued[i] = 0;
      ap[i] = 0;
    end
    total = 0;
    for (int c = 0; c < 500; c++) begin
      rr = $urandom_range(0, 3);
      if (issued[rr] - rel_cnt[rr] < 4 && $urandom_range(0, 1) == 1) begin
        pool.push_back(rr*4 + ap[rr]);
        ap[rr] = (ap[rr] + 1) % 4;
        issued[rr]++;
        total++;
      end
      ordy = ($urandom_range(0, 3) != 0);
      if (pool.size() > 0 && $urandom_range(0, 4) != 0) begin
        pi  = $urandom_range(0, pool.size() - 1);
        acc = !mv[pool[pi]];
        drive(1, pool[pi], $urandom, 2'($urandom), ordy);
        if (acc) pool.delete(pi);
      end else begin
        drive(0, 0, 0, 0, ordy);
      end
    end
    for (int c = 0; c < 100 && pool.size() > 0; c++) begin
      acc = !mv[pool[0]];
      drive(1, pool[0], $urandom, 2'($urandom), 1);
      if (acc) pool.delete(0);
    end
    repeat (40) drive(0, 0, 0, 0, 1);
    chk("rand_all_released", 64'(log_uid.size()), 64'(total));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
